// File: rtl/fifo_cmd_issuer_pkg.sv
// rtl/fifo_cmd_issuer_pkg.sv - opcodes, FSM states and tag type shared by the FIFO command issuer
package fifo_cmd_issuer_pkg;

    localparam int OPCODE_WIDTH = 2;

    // Opcode field of the {opcode,data} command word; OP_INVALID is never driven
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_INVALID = 2'b11
    } opcode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Encoding of the arbiter's registered last grant
    localparam logic GRANT_WRITE = 1'b0;
    localparam logic GRANT_READ  = 1'b1;

    // One read in flight: keep=0 marks a flush read whose data is discarded
    typedef struct packed {
        logic valid;
        logic keep;
    } tag_t;

    // Occupancy counter width able to hold 0..entries
    function automatic int cnt_width(input int entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/fifo_cmd_issuer_if.sv
// rtl/fifo_cmd_issuer_if.sv - producer/consumer/flush ports and fifo-side command bus of the issuer
interface fifo_cmd_issuer_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int NUM_ENTRIES = 8
);
    import fifo_cmd_issuer_pkg::*;

    localparam int CNT_W = cnt_width(NUM_ENTRIES);

    logic                               wr_req;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic                               wr_ready;
    logic                               rd_req;
    logic                               rd_ready;
    logic [DATA_WIDTH-1:0]              rd_data;
    logic                               rd_valid;
    logic                               flush_req;
    logic                               flush_busy;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_out;
    logic [DATA_WIDTH-1:0]              fifo_data_in;
    logic [CNT_W-1:0]                   count;

    // Client side: producer, consumer, flush controller and the fifo data return
    modport master (
        output wr_req, wr_data, rd_req, flush_req, fifo_data_in,
        input  wr_ready, rd_ready, rd_data, rd_valid, flush_busy, vector_out, count
    );

    // Issuer side
    modport slave (
        input  wr_req, wr_data, rd_req, flush_req, fifo_data_in,
        output wr_ready, rd_ready, rd_data, rd_valid, flush_busy, vector_out, count
    );

endinterface

// File: rtl/fifo_cmd_issuer_rr_arbiter_2.sv
// rtl/fifo_cmd_issuer_rr_arbiter_2.sv - two-requester round-robin with registered last grant
module fifo_cmd_issuer_rr_arbiter_2
    import fifo_cmd_issuer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req0,
    input  logic ok0,
    input  logic req1,
    input  logic ok1,
    output logic ready0,
    output logic ready1
);

    // Requester 0 is the write port, requester 1 the read port
    logic last_q;
    logic contention;

    assign contention = req0 & ok0 & req1 & ok1;
    assign ready0     = enable & ok0 & (!contention | (last_q == GRANT_READ));
    assign ready1     = enable & ok1 & (!contention | (last_q == GRANT_WRITE));

    // Remember who won last; idle cycles leave the history untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= GRANT_READ;
        end else if (req0 && ready0) begin
            last_q <= GRANT_WRITE;
        end else if (req1 && ready1) begin
            last_q <= GRANT_READ;
        end
    end

endmodule

// File: rtl/fifo_cmd_issuer.sv
// rtl/fifo_cmd_issuer.sv - turns write/read/flush requests into one registered fifo command per clock
module fifo_cmd_issuer
    import fifo_cmd_issuer_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int NUM_ENTRIES = 8
)
(
    input  logic               clk,
    input  logic               reset,
    fifo_cmd_issuer_if.slave   bus
);

    localparam int CNT_W = cnt_width(NUM_ENTRIES);
    localparam int VEC_W = OPCODE_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(NUM_ENTRIES);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = '0;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    tag_t                  tag0_q, tag0_d, tag1_q;
    logic [VEC_W-1:0]      vector_q, vector_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    logic run;
    logic wr_ok, rd_ok;
    logic wr_ready, rd_ready;
    logic wr_fire, rd_fire, flush_rd;
    logic pipe_empty;

    assign run        = (state_q == ST_RUN);
    assign wr_ok      = (count_q < FULL_COUNT);
    assign rd_ok      = (count_q != '0);
    assign pipe_empty = !tag0_q.valid && !tag1_q.valid;

    fifo_cmd_issuer_rr_arbiter_2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (run),
        .req0   (bus.wr_req),
        .ok0    (wr_ok),
        .req1   (bus.rd_req),
        .ok1    (rd_ok),
        .ready0 (wr_ready),
        .ready1 (rd_ready)
    );

    // Readies are zero outside RUN, so at most one of these fires per cycle
    assign wr_fire  = bus.wr_req & wr_ready;
    assign rd_fire  = bus.rd_req & rd_ready;
    assign flush_rd = (state_q == ST_FLUSH) & rd_ok;

    // Next state: flush drains the shadow count and waits for in-flight reads to retire
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!rd_ok && pipe_empty) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Command selection: one WRITE, READ (kept or discarded) or NOP per cycle
    always_comb begin
        vector_d = {OP_NOP, ZERO_DATA};
        count_d  = count_q;
        tag0_d   = '0;
        if (wr_fire) begin
            vector_d = {OP_WRITE, bus.wr_data};
            count_d  = count_q + CNT_W'(1);
        end else if (rd_fire) begin
            vector_d    = {OP_READ, ZERO_DATA};
            count_d     = count_q - CNT_W'(1);
            tag0_d.valid = 1'b1;
            tag0_d.keep  = 1'b1;
        end else if (flush_rd) begin
            vector_d    = {OP_READ, ZERO_DATA};
            count_d     = count_q - CNT_W'(1);
            tag0_d.valid = 1'b1;
            tag0_d.keep  = 1'b0;
        end
    end

    // State, shadow count, command register and read-tag pipe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            count_q  <= '0;
            vector_q <= {OP_NOP, ZERO_DATA};
            tag0_q   <= '0;
            tag1_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            vector_q <= vector_d;
            tag0_q   <= tag0_d;
            tag1_q   <= tag0_q;
        end
    end

    // Capture fifo output two edges after the READ was registered; flush data is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= tag1_q.valid & tag1_q.keep;
            if (tag1_q.valid && tag1_q.keep) begin
                rd_data_q <= bus.fifo_data_in;
            end
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.rd_ready   = rd_ready;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.flush_busy = (state_q == ST_FLUSH);
    assign bus.vector_out = vector_q;
    assign bus.count      = count_q;

endmodule

// File: tb/tb_fifo_cmd_issuer.sv
// tb/tb_fifo_cmd_issuer.sv - scoreboard bench for fifo_cmd_issuer with a behavioural fifo behind it
module tb_fifo_cmd_issuer;

    localparam int DW = 4;
    localparam int NE = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    fifo_cmd_issuer_if #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE)) bus ();

    fifo_cmd_issuer #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for fifo_top: executes the registered command on the next edge
    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] fifo_dout;
    assign bus.fifo_data_in = fifo_dout;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem.delete();
            fifo_dout <= '0;
        end else begin
            if (bus.vector_out[5:4] == 2'b10) begin
                fifo_mem.push_back(bus.vector_out[3:0]);
            end else if (bus.vector_out[5:4] == 2'b01 && fifo_mem.size() > 0) begin
                fifo_dout <= fifo_mem.pop_front();
            end
        end
    end

    // Reference model: contents of the fifo as seen by the producer/consumer
    logic [DW-1:0] model_q[$];
    exp_t          exp_q[$];
    bit            last_was_write = 1'b0;
    logic [5:0]    exp_vec = 6'd0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rd_valid strobe must match the oldest outstanding read, on time
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got data %0d expected no strobe (cycle %0d)", bus.rd_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", int'(bus.rd_data), int'(e.data));
                chk("rd_latency", cyc, e.due);
            end
        end
    end

    // One RUN cycle: check last command, drive inputs, check readiness, predict next command
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        bit wok, rok, cont, wrdy, rrdy;
        exp_t e;
        chk("vector_out", int'(bus.vector_out), int'(exp_vec));
        chk("count", int'(bus.count), model_q.size());
        chk("flush_busy_idle", int'(bus.flush_busy), 0);
        bus.wr_req    = w;
        bus.wr_data   = d;
        bus.rd_req    = r;
        bus.flush_req = f;
        #1;
        wok  = model_q.size() < NE;
        rok  = model_q.size() > 0;
        cont = w && wok && r && rok;
        wrdy = wok && (!cont || !last_was_write);
        rrdy = rok && (!cont || last_was_write);
        chk("wr_ready", int'(bus.wr_ready), int'(wrdy));
        chk("rd_ready", int'(bus.rd_ready), int'(rrdy));
        if (w && wrdy) begin
            model_q.push_back(d);
            exp_vec        = {2'b10, d};
            last_was_write = 1'b1;
        end else if (r && rrdy) begin
            e.data = model_q.pop_front();
            e.due  = cyc + 3;
            exp_q.push_back(e);
            exp_vec        = 6'b01_0000;
            last_was_write = 1'b0;
        end else begin
            exp_vec = 6'd0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Flush: requests in the flush cycle still count, then everything stored is drained silently
    task automatic do_flush(input bit w, input logic [DW-1:0] d, input bit r);
        int n, drain, busy, lo, hi;
        bit done;
        step(w, d, r, 1'b1);
        n     = model_q.size();
        model_q.delete();
        drain = n;
        busy  = 0;
        done  = 1'b0;
        for (int g = 0; g < NE + 10; g++) begin
            chk("flush_vector", int'(bus.vector_out), int'(exp_vec));
            chk("flush_count", int'(bus.count), drain);
            if (!bus.flush_busy) begin
                done = 1'b1;
                break;
            end
            busy++;
            bus.flush_req = 1'($urandom_range(0, 1));
            bus.wr_req    = 1'($urandom_range(0, 1));
            bus.rd_req    = 1'($urandom_range(0, 1));
            bus.wr_data   = DW'($urandom);
            #1;
            chk("flush_wr_ready", int'(bus.wr_ready), 0);
            chk("flush_rd_ready", int'(bus.rd_ready), 0);
            if (drain > 0) begin
                exp_vec = 6'b01_0000;
                drain--;
            end else begin
                exp_vec = 6'd0;
            end
            @(negedge clk);
        end
        chk("flush_ends", int'(done), 1);
        lo = (n == 0) ? 1 : n + 2;
        hi = n + 3;
        total++;
        if (busy < lo || busy > hi) begin
            bad++;
            $display("FAIL flush_busy_len: got %0d cycles expected %0d..%0d for %0d words", busy, lo, hi, n);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_vector_out", int'(bus.vector_out), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_rd_data", int'(bus.rd_data), 0);
        chk("rst_flush_busy", int'(bus.flush_busy), 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next clock edge
    task automatic do_reset();
        #2;
        reset         = 1'b1;
        bus.wr_req    = 1'b0;
        bus.rd_req    = 1'b0;
        bus.flush_req = 1'b0;
        #1;
        check_reset_values();
        model_q.delete();
        exp_q.delete();
        last_was_write = 1'b0;
        exp_vec        = 6'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.wr_req    = 1'b0;
        bus.wr_data   = '0;
        bus.rd_req    = 1'b0;
        bus.flush_req = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset with three words stored and a read in flight
        step(1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b1, 4'h4, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("count_before_reset", int'(bus.count), 3);
        do_reset();
        idle(4);

        // Three writes then three back-to-back reads
        step(1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        idle(4);

        // Fill to full; further writes stall until a read frees a slot
        for (int i = 0; i < NE; i++) step(1'b1, DW'(i + 2), 1'b0, 1'b0);
        chk("full_count", int'(bus.count), NE);
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hA, 1'b1, 1'b0);
        step(1'b1, 4'hA, 1'b0, 1'b0);

        // Down to four, then held contention alternates W,R,W,R
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);

        // Five stored words drained by a flush
        step(1'b1, 4'h7, 1'b0, 1'b0);
        idle(3);
        do_flush(1'b0, 4'h0, 1'b0);

        // Read at empty alongside a write: write wins, read follows
        idle(2);
        step(1'b1, 4'h6, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        idle(3);

        // Flush with nothing stored
        do_flush(1'b0, 4'h0, 1'b0);
        idle(2);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_flush(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                step($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50, 1'b0);
            end
        end
        idle(5);
        chk("reads_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
